scan_uart_tx: RTL and testbench
===============================

Name: scan_uart_tx

Overview:
- UART transmitter. Serialises bytes from the barcode/beat logic onto a single asynchronous output line to the MCU or the scanner configuration port.
- Counterpart of the input synchronizer. The synchronizer brings external asynchronous lines into the clk domain; this block drives a clean, glitch-free asynchronous line out of it.
- Frame format: 8N1, LSB first, idle-high, valid/ready byte handshake on the fabric side.

Parameters:
- CLKS_PER_BIT, 5000, clk cycles per bit period (48 MHz / 9600 baud); legal range 2..65535.
- DATA_BITS, 8, data bits per frame; legal range 5..8.

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-low reset.
- tx_data  input  DATA_BITS  byte to send; sampled only on handshake.
- tx_valid  input  1  producer has a byte.
- tx_ready  output  1  block can accept a byte (high only in IDLE).
- tx  output  1  serial line, registered output, idle high.
- busy  output  1  frame in progress (high in START, DATA, STOP).

Behaviour:
- Clock and reset: one clock domain (clk); reset is asynchronous and active-low.
- Reset values, applied immediately on reset low, including mid-frame:
  - tx=1, tx_ready=1, busy=0.
  - State IDLE, bit counter 0, baud counter 0, shift register 0.
  - A frame aborted by reset is not resumed. The line returns high at once and the held byte is dropped.
- States:
  - IDLE: tx=1, tx_ready=1. On tx_valid && tx_ready:
    - latch tx_data into the shift register;
    - clear the baud counter;
    - go to START.
    - tx_data is a don't-care when tx_valid is low.
  - START: tx=0 for exactly CLKS_PER_BIT cycles, then go to DATA with the bit index at 0.
  - DATA: tx = shift[0] for CLKS_PER_BIT cycles per bit; shift right at each bit boundary. After DATA_BITS bits, go to STOP.
  - STOP: tx=1 for CLKS_PER_BIT cycles, then go to IDLE.
- Latency:
  - tx falls in the first cycle after the handshake cycle, because tx is registered.
  - Frame length from the first start cycle to the end of the stop bit is exactly (DATA_BITS+2)*CLKS_PER_BIT cycles.
- Baud counter:
  - Counts 0..CLKS_PER_BIT-1; the bit boundary is at CLKS_PER_BIT-1.
  - Width is $clog2(CLKS_PER_BIT). It must not overflow at the maximum parameter value.
- Handshake rules:
  - tx_ready deasserts in the cycle after acceptance and stays low for the whole frame.
  - tx_valid held high during a frame has no effect. No second byte is captured and there is no queue.
  - Changes to tx_data during a frame do not alter the bits on the line.
- Back-to-back frames:
  - If tx_valid is high on the IDLE cycle that follows STOP, the next start bit begins one cycle later.
  - The minimum inter-frame line-high time is therefore CLKS_PER_BIT+1 cycles, which is legal since the stop bit is extended by 1 cycle.
- Glitch freedom: tx is driven from a flop only, never from combinational logic.
- Reset release: the first handshake is possible in the first clk edge after reset deasserts with tx_valid high.

Decomposition:
- Package scan_uart_pkg holds:
  - typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_state_t;
  - default constants UART_CLKS_PER_BIT=5000 and UART_DATA_BITS=8.
- One sub-module, baud_counter:
  - parameterised on CLKS_PER_BIT;
  - inputs: clk, reset, clear, enable;
  - output: a one-cycle bit_done pulse at count CLKS_PER_BIT-1.
- The FSM, shift register and bit index stay in scan_uart_tx.

Test Plan:
All scenarios run with CLKS_PER_BIT=4, DATA_BITS=8.
- Single byte: send 0xA5 with a one-cycle tx_valid.
  - tx low 1 cycle after handshake.
  - Line sequence, 4 cycles each: 0,1,0,1,0,0,1,0,1,1 (start, LSB first, stop).
  - busy high exactly 40 cycles; tx_ready returns high after.
- Back-to-back: tx_valid held high with 0x00 then 0xFF.
  - Second start bit begins exactly 41 cycles after the first.
  - Line is high for 5 cycles between frames.
  - Bits match both bytes.
- Data stability: accept 0x3C, then change tx_data to 0xC3 at cycle 10 while tx_valid stays low.
  - Transmitted bits still decode to 0x3C.
  - tx_ready stays low for 40 cycles.
- Reset mid-frame: assert reset at cycle 17 (during data bit 3).
  - tx=1, tx_ready=1, busy=0 in the same cycle, without waiting for a clk edge.
  - After release, sending 0x5A produces a clean full frame.
- Idle hold: tx_valid low for 200 cycles after reset.
  - tx constantly 1, tx_ready constantly 1, busy 0.
  - Changes on tx_data cause no line activity.
- Parameter corner: CLKS_PER_BIT=2, DATA_BITS=5, send 0x15.
  - Frame is exactly 14 cycles.
  - Bits 0,1,0,1,0,1,1 at 2 cycles each.

Source files
------------

// File: rtl/scan_uart_pkg.sv
// Shared types and default constants for the scan UART transmitter.
package scan_uart_pkg;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_state_t;

    localparam int UART_CLKS_PER_BIT = 5000;
    localparam int UART_DATA_BITS    = 8;

endpackage

// File: rtl/scan_uart_tx_if.sv
// Byte handshake between the fabric producer and the UART transmitter.
interface scan_uart_tx_if
    import scan_uart_pkg::*;
#(
    parameter int DATA_BITS = UART_DATA_BITS
);

    logic [DATA_BITS-1:0] tx_data;
    logic                 tx_valid;
    logic                 tx_ready;

    modport master (output tx_data, output tx_valid, input tx_ready);
    modport slave  (input tx_data, input tx_valid, output tx_ready);

endinterface

// File: rtl/scan_uart_tx_baud_counter.sv
// Bit-period timer: pulses bit_done on the last cycle of each bit period.
module baud_counter
    import scan_uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic bit_done
);

    localparam int              CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] count;

    assign bit_done = enable && (count == LAST);

    // Wraps at LAST, so the count never exceeds CLKS_PER_BIT-1 and fits CNT_W bits.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= bit_done ? '0 : count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/scan_uart_tx.sv
// 8N1-style UART transmitter (LSB first, idle high) with a valid/ready byte input.
module scan_uart_tx
    import scan_uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT,
    parameter int DATA_BITS    = UART_DATA_BITS
) (
    input  logic          clk,
    input  logic          reset,
    scan_uart_tx_if.slave bus,
    output logic          tx,
    output logic          busy
);

    localparam int IDX_W = $clog2(DATA_BITS);

    uart_state_t          state;
    logic [DATA_BITS-1:0] shift;
    logic [IDX_W-1:0]     bit_idx;
    logic                 bit_done;
    logic                 accept;
    logic                 counting;

    assign accept   = (state == IDLE) && bus.tx_valid && bus.tx_ready;
    assign counting = (state != IDLE);

    baud_counter #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clk      (clk),
        .reset    (reset),
        .clear    (accept),
        .enable   (counting),
        .bit_done (bit_done)
    );

    // tx, busy and tx_ready are all flops so the line never sees a combinational glitch.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            shift        <= '0;
            bit_idx      <= '0;
            tx           <= 1'b1;
            busy         <= 1'b0;
            bus.tx_ready <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        shift        <= bus.tx_data;
                        state        <= START;
                        tx           <= 1'b0;
                        busy         <= 1'b1;
                        bus.tx_ready <= 1'b0;
                    end
                end
                START: begin
                    if (bit_done) begin
                        state   <= DATA;
                        bit_idx <= '0;
                        tx      <= shift[0];
                    end
                end
                DATA: begin
                    if (bit_done) begin
                        if (bit_idx == IDX_W'(DATA_BITS - 1)) begin
                            state <= STOP;
                            tx    <= 1'b1;
                        end else begin
                            shift   <= shift >> 1;
                            tx      <= shift[1];
                            bit_idx <= bit_idx + IDX_W'(1);
                        end
                    end
                end
                STOP: begin
                    // tx is already high; leaving STOP only re-opens the handshake.
                    if (bit_done) begin
                        state        <= IDLE;
                        busy         <= 1'b0;
                        bus.tx_ready <= 1'b1;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_scan_uart_tx.sv
// Scoreboard bench: stimulus queues expected bytes, a line monitor decodes frames and compares.
module tb_scan_uart_tx;
    import scan_uart_pkg::*;

    localparam int CPB   = 4;
    localparam int NB    = 8;
    localparam int CPB_B = 2;
    localparam int NB_B  = 5;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    logic tx_a, busy_a, tx_b, busy_b;

    scan_uart_tx_if #(.DATA_BITS(NB))   bus_a ();
    scan_uart_tx_if #(.DATA_BITS(NB_B)) bus_b ();

    scan_uart_tx #(.CLKS_PER_BIT(CPB), .DATA_BITS(NB)) dut_a (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_a),
        .tx    (tx_a),
        .busy  (busy_a)
    );

    scan_uart_tx #(.CLKS_PER_BIT(CPB_B), .DATA_BITS(NB_B)) dut_b (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_b),
        .tx    (tx_b),
        .busy  (busy_b)
    );

    always #5 clk = ~clk;

    int cycle = 0;
    always @(posedge clk) cycle <= cycle + 1;

    int tests = 0;
    int fails = 0;
    logic [7:0] exp_q[$];
    int start_q[$];
    int run_q[$];

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        tests++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a byte, wait for the frame slot, and return just after the handshake edge.
    task automatic applyStimulus(input logic [7:0] data, input bit expect_frame);
        int k;
        bus_a.tx_data  = data;
        bus_a.tx_valid = 1'b1;
        if (expect_frame) exp_q.push_back(data);
        k = 0;
        while (bus_a.tx_ready !== 1'b1 && k < 200) begin
            k++;
            tick();
        end
        tick();
        checkOutput("handshake_taken", bus_a.tx_ready, 0);
    endtask

    task automatic waitIdle(input string name);
        int k;
        k = 0;
        while (busy_a === 1'b1 && k < 500) begin
            k++;
            tick();
        end
        checkOutput(name, busy_a, 0);
    endtask

    task automatic grabBit(input int n, output logic val, output logic stable, inout logic aborted);
        val    = 1'b0;
        stable = 1'b1;
        for (int i = 0; i < n; i++) begin
            if (aborted) return;
            @(negedge clk);
            if (!reset) begin
                aborted = 1'b1;
                return;
            end
            if (i == 0) val = tx_a;
            else if (tx_a !== val) stable = 1'b0;
        end
    endtask

    // Decodes every frame on tx_a; run counts line-high samples before each start bit.
    initial begin : monitor
        int run;
        logic [7:0] got;
        logic [7:0] want;
        logic shape_ok, aborted, v, st;
        run = 0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                run = 0;
            end else if (tx_a !== 1'b0) begin
                run++;
            end else begin
                start_q.push_back(cycle);
                run_q.push_back(run);
                aborted = 1'b0;
                got     = '0;
                grabBit(CPB - 1, v, st, aborted);
                shape_ok = (v === 1'b0) && st;
                for (int b = 0; b < NB; b++) begin
                    grabBit(CPB, v, st, aborted);
                    got[b]   = v;
                    shape_ok = shape_ok && st;
                end
                grabBit(CPB, v, st, aborted);
                shape_ok = shape_ok && (v === 1'b1) && st;
                if (aborted) begin
                    run = 0;
                end else begin
                    run = CPB;
                    checkOutput("frame_expected_pending", exp_q.size() != 0, 1);
                    if (exp_q.size() != 0) begin
                        want = exp_q.pop_front();
                        checkOutput("frame_byte", got, want);
                        checkOutput("frame_shape", shape_ok, 1);
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("[TB] FAIL watchdog: simulation did not complete, tests=%0d", tests);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : stimulus
        int n;
        int bad;
        logic [13:0] seq;

        bus_a.tx_valid = 1'b0;
        bus_a.tx_data  = '0;
        bus_b.tx_valid = 1'b0;
        bus_b.tx_data  = '0;

        #1 reset = 1'b0;
        #1;
        checkOutput("reset_tx", tx_a, 1);
        checkOutput("reset_ready", bus_a.tx_ready, 1);
        checkOutput("reset_busy", busy_a, 0);
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;

        // Idle hold with a wandering tx_data.
        bad = 0;
        for (int i = 0; i < 200; i++) begin
            bus_a.tx_data = 8'($urandom);
            tick();
            if (tx_a !== 1'b1 || bus_a.tx_ready !== 1'b1 || busy_a !== 1'b0) bad++;
        end
        checkOutput("idle_bad_cycles", bad, 0);

        // Single byte.
        applyStimulus(8'hA5, 1'b1);
        bus_a.tx_valid = 1'b0;
        checkOutput("a5_tx_low_after_handshake", tx_a, 0);
        n = 0;
        while (busy_a === 1'b1 && n < 200) begin
            n++;
            tick();
        end
        checkOutput("a5_busy_cycles", n, 40);
        checkOutput("a5_ready_after", bus_a.tx_ready, 1);

        // Back-to-back with tx_valid held high.
        repeat (3) tick();
        start_q.delete();
        run_q.delete();
        applyStimulus(8'h00, 1'b1);
        applyStimulus(8'hFF, 1'b1);
        bus_a.tx_valid = 1'b0;
        waitIdle("b2b_done");
        repeat (2) tick();
        checkOutput("b2b_frame_count", start_q.size(), 2);
        if (start_q.size() >= 2) begin
            checkOutput("b2b_start_spacing", start_q[1] - start_q[0], 41);
            checkOutput("b2b_gap_high", run_q[1], 5);
        end

        // Data stability: tx_data changes mid-frame.
        repeat (3) tick();
        applyStimulus(8'h3C, 1'b1);
        bus_a.tx_valid = 1'b0;
        n = 0;
        while (bus_a.tx_ready !== 1'b1 && n < 200) begin
            n++;
            if (n == 10) bus_a.tx_data = 8'hC3;
            tick();
        end
        checkOutput("stab_ready_low_cycles", n, 40);

        // Reset during data bit 3 of 0x96 (line low there).
        repeat (3) tick();
        applyStimulus(8'h96, 1'b0);
        bus_a.tx_valid = 1'b0;
        repeat (16) tick();
        checkOutput("midreset_pre_tx", tx_a, 0);
        #2 reset = 1'b0;
        #1;
        checkOutput("midreset_tx", tx_a, 1);
        checkOutput("midreset_ready", bus_a.tx_ready, 1);
        checkOutput("midreset_busy", busy_a, 0);
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        repeat (2) tick();
        applyStimulus(8'h5A, 1'b1);
        bus_a.tx_valid = 1'b0;
        waitIdle("post_reset_done");
        checkOutput("post_reset_ready", bus_a.tx_ready, 1);

        // Parameter corner: 2 clocks per bit, 5 data bits, 0x15.
        repeat (3) tick();
        bus_b.tx_data  = 5'h15;
        bus_b.tx_valid = 1'b1;
        tick();
        bus_b.tx_valid = 1'b0;
        checkOutput("corner_handshake", bus_b.tx_ready, 0);
        seq = '0;
        n   = 0;
        while (busy_b === 1'b1 && n < 100) begin
            seq = {seq[12:0], tx_b};
            n++;
            tick();
        end
        checkOutput("corner_frame_cycles", n, 14);
        checkOutput("corner_bits", seq, 14'b00110011001111);
        checkOutput("corner_ready_after", bus_b.tx_ready, 1);

        n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            n++;
            tick();
        end
        checkOutput("scoreboard_drained", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
